// File: rtl/primitive_assembler.sv
// -----------------------------------------------------------------------------
// primitive_assembler
//
// Purpose:
//   Turns a stream of screen-space vertices (signed Q16.16) into triangles for
//   list, strip and fan topologies. Supports primitive restart markers and
//   corrects strip winding so every strip triangle keeps the same orientation.
//   One registered triangle is presented per output beat; coordinates pass
//   through bit-exact.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   topo         topology: 0 list, 1 strip, 2 fan, 3 treated as list
//   vin_valid    input beat valid
//   vin_ready    input beat accepted when vin_valid && vin_ready
//   vin_restart  beat is a restart marker (coordinates ignored)
//   vin_x/vin_y  vertex coordinates
//   tri_valid    triangle output valid
//   tri_ready    downstream accepts the presented triangle
//   x0..y2       triangle vertices, winding-corrected
//   tri_id       sequence number of the presented triangle
//   partial_drop one-cycle pulse: a restart discarded an incomplete primitive
// -----------------------------------------------------------------------------
module primitive_assembler #(
    parameter int COORD_W = 32,
    parameter int ID_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         topo,
    input  logic               vin_valid,
    output logic               vin_ready,
    input  logic               vin_restart,
    input  logic [COORD_W-1:0] vin_x,
    input  logic [COORD_W-1:0] vin_y,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x2,
    output logic [COORD_W-1:0] y2,
    output logic [ID_W-1:0]    tri_id,
    output logic               partial_drop
);

    localparam logic [1:0] MODE_LIST  = 2'd0;
    localparam logic [1:0] MODE_STRIP = 2'd1;
    localparam logic [1:0] MODE_FAN   = 2'd2;

    // Assembly state
    logic [1:0]         vcnt_q, vcnt_d;
    logic               parity_q, parity_d;
    logic [1:0]         mode_q, mode_d;
    logic [COORD_W-1:0] ax_q, ax_d, ay_q, ay_d;
    logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
    logic [ID_W-1:0]    cnt_q, cnt_d;

    // Output register
    logic               tri_valid_q, tri_valid_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
    logic [COORD_W-1:0] x2_q, x2_d, y2_q, y2_d;
    logic [ID_W-1:0]    tri_id_q, tri_id_d;
    logic               pd_q, pd_d;

    logic accept;

    // Ready depends only on the output register: a beat is taken whenever the
    // output slot is free or being drained this cycle, even if the beat would
    // not complete a triangle. Held low while in reset.
    assign vin_ready = rst_n && (!tri_valid_q || tri_ready);
    assign accept    = vin_valid && vin_ready;

    always_comb begin
        vcnt_d      = vcnt_q;
        parity_d    = parity_q;
        mode_d      = mode_q;
        ax_d        = ax_q;
        ay_d        = ay_q;
        bx_d        = bx_q;
        by_d        = by_q;
        cnt_d       = cnt_q;
        tri_valid_d = tri_valid_q && !tri_ready;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        x2_d        = x2_q;
        y2_d        = y2_q;
        tri_id_d    = tri_id_q;
        pd_d        = 1'b0;

        if (accept) begin
            if (vin_restart) begin
                vcnt_d   = 2'd0;
                parity_d = 1'b0;
                pd_d     = (vcnt_q != 2'd0);
            end else begin
                case (vcnt_q)
                    2'd0: begin
                        ax_d   = vin_x;
                        ay_d   = vin_y;
                        vcnt_d = 2'd1;
                        // Mode is captured only at the start of a primitive;
                        // the reserved encoding falls back to list.
                        mode_d = (topo == MODE_STRIP || topo == MODE_FAN) ? topo : MODE_LIST;
                    end
                    2'd1: begin
                        bx_d   = vin_x;
                        by_d   = vin_y;
                        vcnt_d = 2'd2;
                    end
                    default: begin
                        // Completing vertex: load the output register.
                        tri_valid_d = 1'b1;
                        tri_id_d    = cnt_q;
                        cnt_d       = cnt_q + 1'b1;
                        x2_d        = vin_x;
                        y2_d        = vin_y;
                        if (mode_q == MODE_STRIP && parity_q) begin
                            // Odd strip triangles swap the first two vertices
                            // to keep a consistent winding.
                            x0_d = bx_q;
                            y0_d = by_q;
                            x1_d = ax_q;
                            y1_d = ay_q;
                        end else begin
                            x0_d = ax_q;
                            y0_d = ay_q;
                            x1_d = bx_q;
                            y1_d = by_q;
                        end
                        case (mode_q)
                            MODE_STRIP: begin
                                ax_d     = bx_q;
                                ay_d     = by_q;
                                bx_d     = vin_x;
                                by_d     = vin_y;
                                parity_d = !parity_q;
                            end
                            MODE_FAN: begin
                                bx_d = vin_x;
                                by_d = vin_y;
                            end
                            default: begin
                                vcnt_d = 2'd0;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt_q      <= 2'd0;
            parity_q    <= 1'b0;
            mode_q      <= MODE_LIST;
            ax_q        <= '0;
            ay_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            cnt_q       <= '0;
            tri_valid_q <= 1'b0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            tri_id_q    <= '0;
            pd_q        <= 1'b0;
        end else begin
            vcnt_q      <= vcnt_d;
            parity_q    <= parity_d;
            mode_q      <= mode_d;
            ax_q        <= ax_d;
            ay_q        <= ay_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            cnt_q       <= cnt_d;
            tri_valid_q <= tri_valid_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            tri_id_q    <= tri_id_d;
            pd_q        <= pd_d;
        end
    end

    assign tri_valid    = tri_valid_q;
    assign x0           = x0_q;
    assign y0           = y0_q;
    assign x1           = x1_q;
    assign y1           = y1_q;
    assign x2           = x2_q;
    assign y2           = y2_q;
    assign tri_id       = tri_id_q;
    assign partial_drop = pd_q;

endmodule

// File: doc/primitive_assembler.md
# primitive_assembler

Assembles a stream of screen-space vertices (Q16.16) into triangles for list, strip and fan topologies, with primitive restart and strip winding correction. It sits directly upstream of the degenerate/backface detector and presents one registered triangle (x0,y0,x1,y1,x2,y2) per output beat. The valid/ready handshake on both sides sustains one vertex per cycle.

## Interface
- COORD_W, 32, vertex coordinate width (signed Q16.16)
- ID_W, 16, triangle ID counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- topo  in  2  topology: 0 list, 1 strip, 2 fan, 3 reserved (treated as list)
- vin_valid  in  1  input beat valid
- vin_ready  out  1  input beat accepted when vin_valid && vin_ready
- vin_restart  in  1  beat is a restart marker only (vin_x/vin_y ignored)
- vin_x, vin_y  in  COORD_W  vertex coordinates
- tri_valid  out  1  triangle output valid
- tri_ready  in  1  downstream accepts
- x0,y0,x1,y1,x2,y2  out  COORD_W each  triangle vertices, winding-corrected
- tri_id  out  ID_W  sequence number of the presented triangle
- partial_drop  out  1  one-cycle pulse: restart discarded an incomplete primitive

## Operation
- State: vcnt (0,1,2), slot A, slot B, parity bit, latched mode, ID counter, one output register.
- vin_ready = !tri_valid || tri_ready, in every cycle, including beats that complete no triangle.
- Mode is latched from topo on the accepted non-restart vertex with vcnt==0. topo changes while vcnt!=0 are ignored.
- Restart beat (accepted, vin_restart=1): vcnt←0, parity←0, no triangle. partial_drop pulses the next cycle if vcnt!=0 at acceptance, or if list mode was mid-triangle.
- Vertex beat, vcnt==0: A←v, vcnt←1. vcnt==1: B←v, vcnt←2.
- Vertex beat, vcnt==2 (completing vertex):
  - list: emit (A,B,v); vcnt←0.
  - strip: parity 0 emits (A,B,v); parity 1 emits (B,A,v). Then A←B, B←v, parity toggles, vcnt stays 2.
  - fan: emit (A,B,v); B←v; A held; vcnt stays 2.
- Emit: output register loads the triangle and tri_id←counter. The counter increments and wraps modulo 2^ID_W.
- No arithmetic on coordinates. Values pass bit-exact.
- Degenerate triangles (repeated vertices) are emitted unchanged, because the downstream detector handles them.

## Timing
- Reset values: tri_valid=0, vin_ready=0 while rst_n low, then 1; x*/y*=0; tri_id=0; partial_drop=0; vcnt=0; parity=0; mode=list; counter=0.
- Latency: a triangle is valid the cycle after its completing vertex is accepted.
- Throughput: one vertex per cycle. Strip and fan produce one triangle per cycle at steady state.
- Output holds stable while tri_valid && !tri_ready.
- Simultaneous tri_ready and a completing vertex in the same cycle: the output register reloads with no bubble and tri_valid stays 1.
- Non-completing vertex while stalled: not accepted (vin_ready=0). This rule is uniform and simplifies skid logic.
- Reset asserted mid-primitive or mid-stall: all state clears immediately and the pending triangle is lost.
- ID wrap: after 2^ID_W−1 the next tri_id is 0.

## Test plan
- List, tri_ready=1, vertices (0,0),(0x10000,0),(0,0x10000),(1,1),(2,2),(3,3):
  - two triangles with tri_id 0,1;
  - first triangle valid one cycle after the third vertex.
- Strip with vertices V0..V4 (distinct coordinates):
  - emits (V0,V1,V2), (V2,V1,V3), (V2,V3,V4) on consecutive cycles;
  - all three keep the same winding.
- Fan with V0..V4:
  - emits (V0,V1,V2), (V0,V2,V3), (V0,V3,V4);
  - a topo change to list mid-fan is ignored until after a restart.
- Restart after two strip vertices:
  - partial_drop pulses one cycle and no triangle is emitted;
  - the next three vertices form a triangle with parity 0 ordering.
- Backpressure: hold tri_ready=0 for 5 cycles during a strip:
  - vin_ready=0 and outputs stable throughout;
  - release gives back-to-back triangles with no loss or duplication, and tri_id is contiguous.
- Reset asserted during a stalled triangle:
  - tri_valid drops asynchronously and all outputs return to reset values;
  - after release, a list triangle gets tri_id 0.
